// File: rtl/nerv_led_pkg.sv
// nerv_led_pkg: shared definitions for the NERV LED output stage.
//   - bit positions of the fields inside the SoC `leds` register word
//   - blink mode encoding and the decoded configuration record
//   - helpers to decode a register word and select the blink phase
// Build option: NERV_LED_BLINK_EN (when undefined the blink field is
// decoded as STEADY, so every blink setting behaves as steady).
package nerv_led_pkg;

   localparam int unsigned LED_EN_LSB    = 0;
   localparam int unsigned LED_EN_W      = 7;
   localparam int unsigned LED_DUTY_LSB  = 16;
   localparam int unsigned LED_BLINK_LSB = 20;

   localparam logic [3:0] DUTY_FULL = 4'hF;

   typedef enum logic [1:0] {
      STEADY = 2'b00,
      SLOW   = 2'b01,
      FAST   = 2'b10,
      RSVD   = 2'b11
   } blink_mode_t;

   typedef struct packed {
      blink_mode_t           blink;
      logic [3:0]            duty;
      logic [LED_EN_W-1:0]   en;
   } led_cfg_t;

   function automatic led_cfg_t unpack_cfg(input logic [31:0] word);
      led_cfg_t c;
      c.en   = word[LED_EN_LSB +: LED_EN_W];
      c.duty = word[LED_DUTY_LSB +: 4];
`ifdef NERV_LED_BLINK_EN
      c.blink = blink_mode_t'(word[LED_BLINK_LSB +: 2]);
`else
      c.blink = STEADY;
`endif
      return c;
   endfunction

   // RSVD behaves like STEADY.
   function automatic logic blink_phase(input blink_mode_t mode,
                                        input logic        slow,
                                        input logic        fast);
      logic ph;
      case (mode)
         SLOW:    ph = slow;
         FAST:    ph = fast;
         default: ph = 1'b1;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/nerv_led_timebase.sv
// nerv_led_timebase: PWM time base for the LED output stage.
// Ports:
//   i_clock       system clock
//   i_resetn      synchronous reset, active-low
//   o_tick        one cycle per PRESCALE clocks (prescaler at its last count)
//   o_boundary    tick on the last PWM step, i.e. end of a PWM period
//   o_pwm_cnt     4-bit PWM step, advances on tick, wraps 15 -> 0
//   o_slow_phase  blink phase, bit 9 of the period counter
//   o_fast_phase  blink phase, bit 7 of the period counter
// Build option: NERV_LED_BLINK_EN (period counter present only when defined;
// otherwise both phases are constant 1).
module nerv_led_timebase #(
   parameter int unsigned PRESCALE = 750
) (
   input  logic       i_clock,
   input  logic       i_resetn,
   output logic       o_tick,
   output logic       o_boundary,
   output logic [3:0] o_pwm_cnt,
   output logic       o_slow_phase,
   output logic       o_fast_phase
);

   localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] r_pre;
   logic [3:0]       r_pwm_cnt;
   logic             w_tick;
   logic             w_boundary;

   assign w_tick     = (r_pre == PRE_LAST);
   assign w_boundary = w_tick && (r_pwm_cnt == 4'hF);

   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_pre     <= '0;
         r_pwm_cnt <= '0;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
         if (w_tick)
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
      end
   end

`ifdef NERV_LED_BLINK_EN
   // Free-running period counter; mode changes never clear it.
   logic [9:0] r_blink_cnt;

   always_ff @(posedge i_clock) begin
      if (!i_resetn)
         r_blink_cnt <= '0;
      else if (w_boundary)
         r_blink_cnt <= r_blink_cnt + 10'd1;
   end

   assign o_slow_phase = r_blink_cnt[9];
   assign o_fast_phase = r_blink_cnt[7];
`else
   assign o_slow_phase = 1'b1;
   assign o_fast_phase = 1'b1;
`endif

   assign o_tick     = w_tick;
   assign o_boundary = w_boundary;
   assign o_pwm_cnt  = r_pwm_cnt;

endmodule

// File: rtl/nerv_led_pwm.sv
// nerv_led_pwm: LED output stage between the SoC `leds` register and the
// board LED pins. Per-LED enable, global 16-step PWM brightness, optional
// blinking, per-pin polarity correction. Configuration is captured every
// cycle but only applied at PWM period boundaries, so pins never glitch.
// Ports:
//   clock     system clock
//   resetn    synchronous reset, active-low
//   leds      SoC LED register word ([6:0] enable, [19:16] duty, [21:20] blink)
//   led_pins  registered pin drive, NUM_LEDS wide (ACTIVE_LOW_MASK = all dark)
// Build option: NERV_LED_BLINK_EN enables blink decoding; when undefined
// every blink setting behaves as steady.
module nerv_led_pwm
   import nerv_led_pkg::*;
#(
   parameter int unsigned          NUM_LEDS        = 7,
   parameter logic [NUM_LEDS-1:0]  ACTIVE_LOW_MASK = NUM_LEDS'(7'b1100000),
   parameter int unsigned          PRESCALE        = 750
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [31:0]         leds,
   output logic [NUM_LEDS-1:0] led_pins
);

   led_cfg_t            r_cfg_q;
   led_cfg_t            r_cfg_act;
   logic                w_tick;
   logic                w_boundary;
   logic [3:0]          w_pwm_cnt;
   logic                w_slow_phase;
   logic                w_fast_phase;
   logic                w_phase;
   logic                w_duty_hit;
   logic [NUM_LEDS-1:0] w_en;
   logic [NUM_LEDS-1:0] w_on;
   logic                w_unused;

   nerv_led_timebase #(
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .i_clock      (clock),
      .i_resetn     (resetn),
      .o_tick       (w_tick),
      .o_boundary   (w_boundary),
      .o_pwm_cnt    (w_pwm_cnt),
      .o_slow_phase (w_slow_phase),
      .o_fast_phase (w_fast_phase)
   );

   // Shadow update: a word captured on the boundary edge itself is only
   // picked up at the following boundary.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_cfg_q   <= '0;
         r_cfg_act <= '0;
      end else begin
         r_cfg_q <= unpack_cfg(leds);
         if (w_boundary)
            r_cfg_act <= r_cfg_q;
      end
   end

`ifdef NERV_LED_BLINK_EN
   assign w_phase  = blink_phase(r_cfg_act.blink, w_slow_phase, w_fast_phase);
   assign w_unused = ^{w_tick, leds[31:22], leds[15:7]};
`else
   assign w_phase  = 1'b1;
   assign w_unused = ^{w_tick, w_slow_phase, w_fast_phase, r_cfg_act.blink,
                       leds[31:20], leds[15:7]};
`endif

   // Full duty bypasses the compare so there is no dark step at the wrap.
   assign w_duty_hit = (r_cfg_act.duty == DUTY_FULL) || (w_pwm_cnt < r_cfg_act.duty);

   // Zero-extend (or truncate) the 7 enables; pins above bit 6 stay off.
   assign w_en = NUM_LEDS'(r_cfg_act.en);
   assign w_on = w_en & {NUM_LEDS{w_phase & w_duty_hit}};

   always_ff @(posedge clock) begin
      if (!resetn)
         led_pins <= ACTIVE_LOW_MASK;
      else
         led_pins <= w_on ^ ACTIVE_LOW_MASK;
   end

endmodule

// File: tb/tb_nerv_led_pwm.sv
// Testbench for nerv_led_pwm with PRESCALE = 4 (64-cycle PWM period).
module tb_nerv_led_pwm;

   localparam int unsigned P      = 4;
   localparam int unsigned PER    = 16 * P;
   localparam logic [6:0]  MASK   = 7'b1100000;
   localparam logic [6:0]  ALL_ON = 7'b0011111;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] leds;
   logic [6:0]  led_pins;

   nerv_led_pwm #(
      .NUM_LEDS        (7),
      .ACTIVE_LOW_MASK (MASK),
      .PRESCALE        (P)
   ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .leds     (leds),
      .led_pins (led_pins)
   );

   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference state: edges seen with resetn high since the last reset,
   // plus the captured and active register words.
   int          n_edge    = 0;
   logic [31:0] m_cfg_q   = '0;
   logic [31:0] m_cfg_act = '0;
   logic [6:0]  exp_q[$];
   bit          started   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_total++;
      n_fail++;
      $error("FAIL %s: observed wait expired, expected event", tag);
   endtask

   // Expected pins driven by edge n (n >= 1), from the state after edge n-1.
   function automatic logic [6:0] model_pins(input logic [31:0] act, input int n);
      int unsigned pwm;
      logic [9:0]  bc;
      logic [3:0]  duty;
      logic        ph;
      pwm  = ((n - 1) / P) % 16;
      bc   = 10'(((n - 1) / PER) % 1024);
      duty = act[19:16];
      ph   = 1'b1;
`ifdef NERV_LED_BLINK_EN
      case (act[21:20])
         2'b01:   ph = bc[9];
         2'b10:   ph = bc[7];
         default: ph = 1'b1;
      endcase
`else
      ph = (bc == bc);
`endif
      if (ph && (duty == 4'hF || pwm < duty))
         return act[6:0] ^ MASK;
      return MASK;
   endfunction

   // Push the expectation for every edge.
   always @(posedge clock) begin
      started = 1;
      if (!resetn) begin
         exp_q.push_back(MASK);
         n_edge    = 0;
         m_cfg_q   = '0;
         m_cfg_act = '0;
      end else begin
         n_edge++;
         exp_q.push_back(model_pins(m_cfg_act, n_edge));
         if (n_edge % PER == 0)
            m_cfg_act = m_cfg_q;
         m_cfg_q = leds;
      end
   end

   // Pop and compare away from the active edge.
   always @(negedge clock) begin
      if (started) begin
         if (exp_q.size() == 0)
            timeout_fail("sb_empty");
         else
            check("scoreboard", led_pins, exp_q.pop_front());
      end
   end

   task automatic wait_edge(input int k, input string tag);
      for (int i = 0; i < 4 * PER; i++) begin
         if (n_edge == k) return;
         @(negedge clock);
      end
      timeout_fail(tag);
   endtask

   task automatic wait_period_start();
      @(negedge clock);
      for (int i = 0; i < PER + 2; i++) begin
         if (n_edge % PER == 0) return;
         @(negedge clock);
      end
      timeout_fail("period_start");
   endtask

   task automatic wait_pwm(input int unsigned step);
      for (int i = 0; i < 2 * PER; i++) begin
         if (n_edge > 0 && ((n_edge / P) % 16) == step) return;
         @(negedge clock);
      end
      timeout_fail("wait_pwm");
   endtask

   task automatic measure(input int cycles, input logic [6:0] sel,
                          input logic [6:0] val, output int hits);
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if ((led_pins & sel) == val) hits++;
      end
   endtask

   initial begin
      int hits;

      // Reset hold with all bits set.
      resetn = 1'b0;
      leds   = 32'hFFFF_FFFF;
      repeat (2) @(negedge clock);
      check("reset_pins", led_pins, MASK);
      resetn = 1'b1;
      wait_edge(64, "wait_64");
      check("dark_at_64", led_pins, MASK);
      @(negedge clock);
      check("on_at_65", led_pins, ALL_ON);

      // Half duty, steady: 32 on, 32 off.
      leds = 32'h0008_007F;
      wait_period_start();
      measure(PER, 7'h7F, ALL_ON, hits);
      check("half_on_cycles", hits, 32);
      measure(PER, 7'h7F, MASK, hits);
      check("half_off_cycles", hits, 32);

      // Duty 0: always dark.
      leds = 32'h0000_007F;
      wait_period_start();
      measure(PER, 7'h7F, MASK, hits);
      check("duty0_dark", hits, PER);

      // Duty 15: continuously on across the wrap.
      leds = 32'h000F_007F;
      wait_period_start();
      measure(2 * PER, 7'h7F, ALL_ON, hits);
      check("duty15_on", hits, 2 * PER);

      // Shadow update: duty 4 -> 12 at pwm_cnt 2.
      leds = 32'h0004_0001;
      wait_period_start();
      hits = 0;
      for (int i = 0; i < int'(PER); i++) begin
         @(negedge clock);
         if (led_pins[0]) hits++;
         if (n_edge % PER == 2 * P) leds = 32'h000C_0001;
      end
      check("shadow_cur_on", hits, 16);
      measure(PER, 7'h01, 7'h01, hits);
      check("shadow_next_on", hits, 48);

      // Word change landing on the boundary edge waits one more period.
      wait_period_start();
      for (int i = 0; i < int'(PER) + 2; i++) begin
         if (n_edge % PER == PER - 1) break;
         @(negedge clock);
      end
      leds = 32'h0002_0001;
      @(negedge clock);
      measure(PER, 7'h01, 7'h01, hits);
      check("same_edge_old", hits, 48);
      measure(PER, 7'h01, 7'h01, hits);
      check("same_edge_new", hits, 8);

      // Fast blink, full duty, LED0 only, over 256 periods.
      leds = 32'h002F_0001;
      wait_period_start();
      measure(256 * PER, 7'h01, 7'h01, hits);
`ifdef NERV_LED_BLINK_EN
      check("blink_fast_on", hits, 128 * PER);
`else
      check("blink_off_steady", hits, 256 * PER);
`endif

      // Reset for one cycle mid-period.
      leds = 32'hFFFF_FFFF;
      wait_pwm(7);
      resetn = 1'b0;
      @(negedge clock);
      check("midreset_pins", led_pins, MASK);
      resetn = 1'b1;
      wait_edge(64, "wait_64_again");
      check("restart_dark_64", led_pins, MASK);
      @(negedge clock);
      check("restart_on_65", led_pins, ALL_ON);

      @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
